// File: rtl/clear_plot_ctrl.sv
// clear_plot_ctrl: arbitrates single-pixel draws against full-screen clear sweeps into one registered plot stream.
// Optional macro CLEAR_PLOT_DROP_CNT_EN adds the drop_cnt output (saturating count of accepted out-of-range draws).
module clear_plot_ctrl #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clr_colour,
  input  logic [7:0]          sweep_x,
  input  logic [7:0]          sweep_y,
  output logic                sweep_lock,
  input  logic                draw_valid,
  input  logic [7:0]          draw_x,
  input  logic [6:0]          draw_y,
  input  logic [COLOUR_W-1:0] draw_colour,
  output logic                draw_ready,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
`ifdef CLEAR_PLOT_DROP_CNT_EN
  output logic [7:0]          drop_cnt,
`endif
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [14:0] PIX_LAST = 15'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]  X_LIM    = 8'(WIDTH);
  localparam logic [6:0]  Y_LIM    = 7'(HEIGHT);

  function automatic logic in_range_f(input logic [7:0] x, input logic [6:0] y);
    return (x < X_LIM) && (y < Y_LIM);
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic [14:0]           pix_cnt_r;
  logic                  clear_pend_r;
  logic [6:0]            y_hold_r;
  logic [COLOUR_W-1:0]   clr_col_r;
  logic                  enter_clear_s;
  logic                  draw_fire_s;
  logic                  draw_ok_s;
  logic                  row_start_s;
  logic [6:0]            plot_y_s;
  logic                  unused_s;

  // Rows are at most 7 bits wide, so the counter's top Y bit carries no information here.
  assign unused_s   = sweep_y[7];

  assign sweep_lock = (state_r == ST_CLEAR);
  assign busy       = (state_r == ST_CLEAR);
  assign draw_ready = (state_r == ST_IDLE) & ~clear_pend_r & ~clear_req;

  // Next-state decode plus the row-end Y correction for the sweep counter.
  always_comb begin
    state_nxt_s   = state_r;
    enter_clear_s = 1'b0;
    draw_fire_s   = draw_valid & draw_ready;
    draw_ok_s     = in_range_f(draw_x, draw_y);
    // The counter bumps Y early at the row end, so Y is trusted only at row start or on entry.
    row_start_s   = (sweep_x == 8'd0) || (pix_cnt_r == 15'd0);
    plot_y_s      = row_start_s ? sweep_y[6:0] : y_hold_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_req || clear_pend_r) begin
          state_nxt_s   = ST_CLEAR;
          enter_clear_s = 1'b1;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (pix_cnt_r == PIX_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_DONE: begin
        if (clear_pend_r || clear_req) begin
          state_nxt_s   = ST_CLEAR;
          enter_clear_s = 1'b1;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, clear bookkeeping and the registered plot stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pix_cnt_r    <= 15'd0;
      clear_pend_r <= 1'b0;
      y_hold_r     <= 7'd0;
      clr_col_r    <= '0;
      vga_x        <= 8'd0;
      vga_y        <= 7'd0;
      vga_colour   <= '0;
      vga_plot     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done    <= (state_r == ST_DONE);
      if (enter_clear_s) begin
        clear_pend_r <= 1'b0;
      end else if (clear_req && (state_r != ST_IDLE)) begin
        clear_pend_r <= 1'b1;
      end
      pix_cnt_r <= (state_r == ST_CLEAR) ? (pix_cnt_r + 15'd1) : 15'd0;
      if (enter_clear_s) begin
        clr_col_r <= clr_colour;
      end
      if ((state_r == ST_CLEAR) && row_start_s) begin
        y_hold_r <= sweep_y[6:0];
      end
      case (state_r)
        ST_IDLE: begin
          if (draw_fire_s && draw_ok_s) begin
            vga_x      <= draw_x;
            vga_y      <= draw_y;
            vga_colour <= draw_colour;
            vga_plot   <= 1'b1;
          end else begin
            vga_plot   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          vga_x      <= sweep_x;
          vga_y      <= plot_y_s;
          vga_colour <= clr_col_r;
          vga_plot   <= 1'b1;
        end
        default: begin
          vga_plot <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLEAR_PLOT_DROP_CNT_EN
  // Saturating count of accepted-but-dropped draws, restarted by every clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (enter_clear_s) begin
      drop_cnt <= 8'd0;
    end else if (draw_fire_s && !draw_ok_s && (drop_cnt != 8'd255)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clear_plot_ctrl.sv
// Scoreboard bench for clear_plot_ctrl: stimulus pushes expected plots, a negedge monitor pops and compares.
module tb_clear_plot_ctrl;

  localparam int W = 160;
  localparam int H = 120;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic [2:0] clr_colour = 3'd0;
  logic [7:0] sx_m = 8'd0;
  logic [7:0] sy_m = 8'd0;
  logic       sweep_lock;
  logic       draw_valid = 1'b0;
  logic [7:0] draw_x = 8'd0;
  logic [6:0] draw_y = 7'd0;
  logic [2:0] draw_colour = 3'd0;
  logic       draw_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;
`ifdef CLEAR_PLOT_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  clear_plot_ctrl dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clr_colour(clr_colour),
    .sweep_x(sx_m), .sweep_y(sy_m), .sweep_lock(sweep_lock),
    .draw_valid(draw_valid), .draw_x(draw_x), .draw_y(draw_y), .draw_colour(draw_colour),
    .draw_ready(draw_ready), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy),
`ifdef CLEAR_PLOT_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Environment: sweep counter that advances X on posedge and Y on negedge at the row end.
  always @(posedge clk) if (sweep_lock) sx_m <= (sx_m == 8'd159) ? 8'd0 : sx_m + 8'd1;
  always @(negedge clk) if (sweep_lock && sx_m == 8'd159) sy_m <= (sy_m == 8'd119) ? 8'd0 : sy_m + 8'd1;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];
  pix_t e_m;
  int checks = 0;
  int errors = 0;
  int plots_seen = 0;
  int done_cnt = 0;
  int lock_cnt = 0;
  int drops = 0;

  // Monitor: every plot strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (vga_plot) begin
      plots_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) with no plot expected", vga_x, vga_y, vga_colour);
      end else begin
        e_m = exp_q.pop_front();
        if (int'(vga_x) != e_m.x || int'(vga_y) != e_m.y || int'(vga_colour) != e_m.c) begin
          errors++;
          $display("FAIL plot_%0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)", plots_seen,
                   vga_x, vga_y, vga_colour, e_m.x, e_m.y, e_m.c);
        end
      end
    end
    if (done) done_cnt++;
    if (sweep_lock) lock_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference for a clear: raster order from the counter's start position, wrapping the whole screen.
  task automatic push_clear(input int c, input int sx, input int sy);
    for (int i = 0; i < NPIX; i++) begin
      int lin;
      pix_t p;
      lin = (sy * W + sx + i) % NPIX;
      p.x = lin % W;
      p.y = lin / W;
      p.c = c;
      exp_q.push_back(p);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_draw(input int x, input int y, input int c, output int rdy_first);
    int t;
    pix_t p;
    draw_valid = 1'b1;
    draw_x = 8'(x);
    draw_y = 7'(y);
    draw_colour = 3'(c);
    t = 0;
    @(negedge clk);
    rdy_first = int'(draw_ready);
    while (!draw_ready && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (!draw_ready) begin
      chk("draw_ready_timeout", 0, 1);
    end else if (x < W && y < H) begin
      p.x = x; p.y = y; p.c = c;
      exp_q.push_back(p);
    end else begin
      drops++;
    end
    @(posedge clk);
    #1;
    draw_valid = 1'b0;
  endtask

  task automatic wait_plots(input int target, input int budget);
    int t;
    t = 0;
    while (plots_seen < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (plots_seen < target) chk("wait_plots_timeout", plots_seen, target);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int t;
    t = 0;
    while (done_cnt < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt < target) chk("wait_done_timeout", done_cnt, target);
    #1;
  endtask

  initial begin
    int rdy, p0, l0, d0, sx0, sy0, c1, c2;

    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_vga_plot", int'(vga_plot), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_vga_colour", int'(vga_colour), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sweep_lock", int'(sweep_lock), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Single in-range draw, one-cycle latency
    do_draw(10, 20, 5, rdy);
    chk("draw_ready_idle", rdy, 1);
    @(negedge clk);
    chk("draw_plot", int'(vga_plot), 1);
    chk("draw_x", int'(vga_x), 10);
    chk("draw_y", int'(vga_y), 20);
    chk("draw_colour", int'(vga_colour), 5);
    @(posedge clk);
    #1;

    // Out-of-range draws are accepted and dropped
    do_draw(160, 0, 3, rdy);
    chk("oor_x_ready", rdy, 1);
    do_draw(0, 120, 3, rdy);
    chk("oor_y_ready", rdy, 1);
    @(negedge clk);
    chk("oor_plot", int'(vga_plot), 0);
`ifdef CLEAR_PLOT_DROP_CNT_EN
    chk("drop_cnt_two", int'(drop_cnt), 2);
`endif
    @(posedge clk);
    #1;

    // Randomised draw traffic, back-to-back and gapped
    for (int i = 0; i < 150; i++) begin
      do_draw(int'($urandom_range(0, 175)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), rdy);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    chk("draws_drained", exp_q.size(), 0);
`ifdef CLEAR_PLOT_DROP_CNT_EN
    chk("drop_cnt_random", int'(drop_cnt), (drops > 255) ? 255 : drops);
`endif

    // Clear and draw in the same IDLE cycle: clear wins, draw waits
    p0 = plots_seen; l0 = lock_cnt; d0 = done_cnt;
    clear_req = 1'b1;
    clr_colour = 3'd2;
    push_clear(2, int'(sx_m), int'(sy_m));
    fork
      do_draw(33, 44, 6, rdy);
      begin
        @(posedge clk);
        #1;
        clear_req = 1'b0;
      end
    join
    chk("draw_ready_vs_clear", rdy, 0);
    chk("done_before_draw", done_cnt - d0, 1);
    idle(4);
    chk("clear1_plots", plots_seen - p0, NPIX + 1);
    chk("clear1_lock_cycles", lock_cnt - l0, NPIX);
    chk("clear1_done_pulses", done_cnt - d0, 1);
    chk("clear1_drained", exp_q.size(), 0);
`ifdef CLEAR_PLOT_DROP_CNT_EN
    chk("drop_cnt_cleared", int'(drop_cnt), 0);
`endif

    // Reset part-way through a clear aborts it without a done pulse
    p0 = plots_seen; d0 = done_cnt;
    clear_req = 1'b1;
    clr_colour = 3'(int'($urandom_range(0, 7)));
    push_clear(int'(clr_colour), int'(sx_m), int'(sy_m));
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    wait_plots(p0 + 8000, 20000);
    chk("busy_mid_clear", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_sweep_lock", int'(sweep_lock), 0);
    chk("abort_vga_plot", int'(vga_plot), 0);
    chk("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    chk("abort_no_done", done_cnt - d0, 0);

    // Fresh clear from wherever the counter stopped, with a second clear requested at pixel 5000
    p0 = plots_seen; l0 = lock_cnt; d0 = done_cnt;
    sx0 = int'(sx_m); sy0 = int'(sy_m);
    c1 = int'($urandom_range(0, 7));
    c2 = (c1 + int'($urandom_range(1, 7))) % 8;
    clear_req = 1'b1;
    clr_colour = 3'(c1);
    push_clear(c1, sx0, sy0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    wait_plots(p0 + 5000, 10000);
    clear_req = 1'b1;
    clr_colour = 3'(c2);
    push_clear(c2, sx0, sy0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    wait_done(d0 + 2, 45000);
    idle(4);
    chk("double_clear_plots", plots_seen - p0, 2 * NPIX);
    chk("double_clear_lock", lock_cnt - l0, 2 * NPIX);
    chk("double_clear_done", done_cnt - d0, 2);
    chk("double_clear_drained", exp_q.size(), 0);
    chk("idle_after_clears_ready", int'(draw_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clear_plot_ctrl.md
Name: clear_plot_ctrl

Overview:
- Framebuffer write-side controller, downstream of the 160x120 clear-sweep coordinate counter; drives that counter's `lock` input.
- Arbitrates between single-pixel draw requests and full-screen clear sweeps.
- Emits one registered plot stream (x, y, colour, plot) to the VGA framebuffer adapter.
- A clear fills all WIDTH*HEIGHT pixels with `clr_colour`, then pulses `done`.

Parameters:
- WIDTH, 160, pixels per row; x range 0..WIDTH-1.
- HEIGHT, 120, rows; y range 0..HEIGHT-1.
- COLOUR_W, 3, colour bits per pixel.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- clear_req  in  1  single-cycle request to clear the screen.
- clr_colour  in  COLOUR_W  fill colour; sampled on the cycle CLEAR is entered.
- sweep_x  in  8  X coordinate from the sweep counter.
- sweep_y  in  8  Y coordinate from the sweep counter.
- sweep_lock  out  1  advance enable to the sweep counter.
- draw_valid  in  1  draw request valid.
- draw_x  in  8  draw x.
- draw_y  in  7  draw y.
- draw_colour  in  COLOUR_W  draw colour.
- draw_ready  out  1  draw request accepted when high together with draw_valid.
- vga_x  out  8  plot x (registered).
- vga_y  out  7  plot y (registered).
- vga_colour  out  COLOUR_W  plot colour (registered).
- vga_plot  out  1  write strobe (registered).
- busy  out  1  high while in CLEAR.
- done  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-high.
- Reset values: state=IDLE; vga_x/vga_y/vga_colour/vga_plot=0; done=0; clear_pend=0; pix_cnt=0; y_hold=0.
- Reset mid-clear aborts immediately: sweep_lock falls combinationally once state=IDLE, and no done pulse is issued.
- FSM states: IDLE, CLEAR, DONE.
- sweep_lock = (state==CLEAR). It is combinational from state, so the counter advances on the same edge the block samples it.
- draw_ready = (state==IDLE) & ~clear_pend & ~clear_req.
- IDLE, draw handshake:
  - On a handshake at cycle N, vga_* are loaded from draw_* and vga_plot=1 in cycle N+1.
  - Back-to-back draws run at one per cycle.
- IDLE, out-of-range draws:
  - If draw_x>=WIDTH or draw_y>=HEIGHT, the request is still accepted (handshake completes) but dropped.
  - vga_plot=0 in cycle N+1.
- IDLE, no handshake: vga_plot=0 the following cycle.
- clear_req handling:
  - In IDLE: next state is CLEAR. Same-cycle clear_req forces draw_ready low, so clear wins over a simultaneous draw.
  - In CLEAR or DONE: clear_pend is set; DONE then returns to CLEAR instead of IDLE.
- CLEAR, per cycle:
  - vga_x <= sweep_x; vga_y <= y_hold-derived value; vga_colour <= latched clr_colour; vga_plot <= 1; pix_cnt++.
  - Exactly WIDTH*HEIGHT plot cycles are issued. Termination is count-based, not coordinate-based, so it works from any counter start position.
- CLEAR, y correction: the counter updates Y on the falling edge while X==WIDTH-1, so raw sweep_y is one row early at the row end.
  - y_hold <= sweep_y only on cycles where sweep_x==0, and on the CLEAR entry cycle.
  - The emitted y is sweep_y when sweep_x==0 or on the entry cycle; otherwise it is y_hold. Truncated to 7 bits.
- CLEAR exit: when pix_cnt==WIDTH*HEIGHT-1, the next state is DONE.
- DONE (one cycle):
  - vga_plot=0, done=1, pix_cnt cleared.
  - clear_pend=1 -> CLEAR (clear_pend cleared, clr_colour resampled); otherwise -> IDLE.
- draw_valid during CLEAR or DONE is held off (ready=0). It is not lost as long as the source holds valid.
- Width rules:
  - pix_cnt is 15 bits.
  - x compare is unsigned 8-bit. Adding 1 to x=WIDTH-1 is never done by this block.

Optional Feature:
- Macro: CLEAR_PLOT_DROP_CNT_EN.
- Defined: adds output port `drop_cnt` (8 bits).
  - Counts accepted out-of-range draws; saturates at 255.
  - Cleared by reset and on each entry to CLEAR.
- Undefined: no port and no counter; out-of-range draws are silently dropped.

Test Plan:
- Reset, then IDLE with draw_valid=1, (x,y,c)=(10,20,5) -> draw_ready=1; next cycle vga_plot=1, vga_x=10, vga_y=20, vga_colour=5.
- Out-of-range draw (160,0,3), then (0,120,3) -> both accepted, vga_plot=0 both cycles; with the macro, drop_cnt=2.
- Counter model starting at (0,0), clear_req with clr_colour=2:
  - Exactly 19200 plot cycles; every (x,y) pair written once with colour 2.
  - Row ends emit (159,y), not (159,y+1).
  - done pulses once; sweep_lock high for exactly 19200 cycles.
- clear_req and draw_valid in the same IDLE cycle -> draw_ready=0; clear runs; the draw is plotted only after done.
- clear_req pulsed mid-clear at pixel 5000 -> after done, a second full 19200-pixel clear runs; two done pulses total.
- reset asserted at pixel 8000 of a clear -> next cycle state IDLE, sweep_lock=0, vga_plot=0, no done pulse; a subsequent clear still emits exactly 19200 plots.
